// File: rtl/rx_packet_sequencer.sv
// Receive-side USB packet sequencer: hunts SYNC, checks the PID, assembles
// payload bytes LSB-first and reports clean completion or an error code at EOP.
module rx_packet_sequencer #(
  parameter int          MAX_BYTES    = 64,
  parameter logic [7:0]  SYNC_PATTERN = 8'h80,
  parameter int          TIMEOUT      = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           rx_active,
  input  logic                           eop,
  input  logic                           bit_valid,
  input  logic                           bit_in,
  output logic                           dec_enable,
  output logic [3:0]                     pid,
  output logic                           pid_valid,
  output logic [7:0]                     byte_out,
  output logic                           byte_valid,
  output logic [$clog2(MAX_BYTES+1)-1:0] byte_count,
  output logic                           pkt_done,
  output logic                           pkt_error,
  output logic [1:0]                     err_code,
  output logic [2:0]                     state_dbg
);

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BYTES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_PID   = 3'd2,
    S_DATA  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [TW-1:0]   tmo, tmo_nxt;
  logic [7:0]      shifted;

  logic            dec_enable_nxt;
  logic [3:0]      pid_nxt;
  logic            pid_valid_nxt;
  logic [7:0]      byte_out_nxt;
  logic            byte_valid_nxt;
  logic [CW-1:0]   byte_count_nxt;
  logic            pkt_done_nxt;
  logic            pkt_error_nxt;
  logic [1:0]      err_code_nxt;

  // New bits enter at bit 7, so after eight shifts the first-received bit sits in bit 0.
  assign shifted   = {bit_in, shreg[7:1]};
  assign state_dbg = state;

  // Strobe semantics: pid_valid, byte_valid, pkt_done and pkt_error are single-cycle
  // pulses with no back-pressure; their data (pid, byte_out, byte_count, err_code)
  // is valid in the same cycle as the pulse and is held afterwards.
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    bit_idx_nxt    = bit_idx;
    tmo_nxt        = tmo;
    pid_nxt        = pid;
    pid_valid_nxt  = 1'b0;
    byte_out_nxt   = byte_out;
    byte_valid_nxt = 1'b0;
    byte_count_nxt = byte_count;
    pkt_done_nxt   = 1'b0;
    pkt_error_nxt  = 1'b0;
    err_code_nxt   = err_code;

    case (state)
      S_IDLE: begin
        if (rx_active) begin
          state_nxt      = S_SYNC;
          shreg_nxt      = 8'h00;
          byte_count_nxt = '0;
        end
      end

      S_SYNC: begin
        if (eop || !rx_active) begin
          state_nxt = S_IDLE;
        end else if (bit_valid) begin
          shreg_nxt = shifted;
          if (shifted == SYNC_PATTERN) begin
            state_nxt   = S_PID;
            bit_idx_nxt = 3'd0;
            tmo_nxt     = '0;
          end
        end
      end

      S_PID, S_DATA: begin
        // eop wins over a coincident bit, which is simply dropped.
        if (eop) begin
          state_nxt = S_IDLE;
          if (state == S_DATA && bit_idx == 3'd0) begin
            pkt_done_nxt = 1'b1;
          end else begin
            pkt_error_nxt = 1'b1;
            err_code_nxt  = 2'd2;
          end
        end else if (!rx_active) begin
          state_nxt     = S_IDLE;
          pkt_error_nxt = 1'b1;
          err_code_nxt  = 2'd3;
        end else if (bit_valid) begin
          tmo_nxt     = '0;
          shreg_nxt   = shifted;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            if (state == S_PID) begin
              if (shifted[7:4] == ~shifted[3:0]) begin
                pid_nxt       = shifted[3:0];
                pid_valid_nxt = 1'b1;
                state_nxt     = S_DATA;
              end else begin
                pkt_error_nxt = 1'b1;
                err_code_nxt  = 2'd1;
                state_nxt     = S_DRAIN;
              end
            end else if (byte_count == MAX_CNT) begin
              pkt_error_nxt = 1'b1;
              err_code_nxt  = 2'd3;
              state_nxt     = S_DRAIN;
            end else begin
              byte_out_nxt   = shifted;
              byte_valid_nxt = 1'b1;
              byte_count_nxt = byte_count + CW'(1);
            end
          end
        end else if (tmo == TMO_LAST) begin
          pkt_error_nxt = 1'b1;
          err_code_nxt  = 2'd3;
          state_nxt     = S_DRAIN;
        end else begin
          tmo_nxt = tmo + TW'(1);
        end
      end

      S_DRAIN: begin
        if (eop || !rx_active) begin
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    dec_enable_nxt = (state_nxt == S_SYNC) || (state_nxt == S_PID) || (state_nxt == S_DATA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      shreg      <= 8'h00;
      bit_idx    <= 3'd0;
      tmo        <= '0;
      dec_enable <= 1'b0;
      pid        <= 4'h0;
      pid_valid  <= 1'b0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      byte_count <= '0;
      pkt_done   <= 1'b0;
      pkt_error  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_idx    <= bit_idx_nxt;
      tmo        <= tmo_nxt;
      dec_enable <= dec_enable_nxt;
      pid        <= pid_nxt;
      pid_valid  <= pid_valid_nxt;
      byte_out   <= byte_out_nxt;
      byte_valid <= byte_valid_nxt;
      byte_count <= byte_count_nxt;
      pkt_done   <= pkt_done_nxt;
      pkt_error  <= pkt_error_nxt;
      err_code   <= err_code_nxt;
    end
  end

endmodule

// File: tb/tb_rx_packet_sequencer.sv
// Directed bench for rx_packet_sequencer: expected output events are queued as
// stimulus is issued and a negedge monitor pops and compares them.
module tb_rx_packet_sequencer;

  localparam int MAX_BYTES = 4;
  localparam int TIMEOUT   = 16;
  localparam int CW        = $clog2(MAX_BYTES + 1);
  localparam int EW        = 18;

  localparam logic [1:0] T_PID  = 2'd0;
  localparam logic [1:0] T_BYTE = 2'd1;
  localparam logic [1:0] T_DONE = 2'd2;
  localparam logic [1:0] T_ERR  = 2'd3;

  logic          clock;
  logic          reset;
  logic          rx_active;
  logic          eop;
  logic          bit_valid;
  logic          bit_in;
  logic          dec_enable;
  logic [3:0]    pid;
  logic          pid_valid;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic [CW-1:0] byte_count;
  logic          pkt_done;
  logic          pkt_error;
  logic [1:0]    err_code;
  logic [2:0]    state_dbg;

  logic [EW-1:0] exp_q[$];
  int            checks;
  int            errors;
  logic          mon_en;

  rx_packet_sequencer #(
    .MAX_BYTES    (MAX_BYTES),
    .SYNC_PATTERN (8'h80),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_active  (rx_active),
    .eop        (eop),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .dec_enable (dec_enable),
    .pid        (pid),
    .pid_valid  (pid_valid),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_count (byte_count),
    .pkt_done   (pkt_done),
    .pkt_error  (pkt_error),
    .err_code   (err_code),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [EW-1:0] ev(input logic [1:0] t, input logic [7:0] d, input logic [7:0] c);
    return {t, d, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic mon_event(input string name, input logic [EW-1:0] got);
    logic [EW-1:0] req;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event act=%0h req=none", name, got);
    end else begin
      req = exp_q.pop_front();
      if (got !== req) begin
        errors++;
        $display("FAIL %s act=%0h req=%0h", name, got, req);
      end
    end
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clock) begin
    if (mon_en) begin
      if (pid_valid)  mon_event("pid_valid",  ev(T_PID, {4'h0, pid}, 8'(byte_count)));
      if (byte_valid) mon_event("byte_valid", ev(T_BYTE, byte_out, 8'(byte_count)));
      if (pkt_done) begin
        check("done_err_exclusive", 32'(pkt_error), 32'd0);
        mon_event("pkt_done", ev(T_DONE, 8'h00, 8'(byte_count)));
      end
      if (pkt_error)  mon_event("pkt_error",  ev(T_ERR, {6'h00, err_code}, 8'(byte_count)));
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic drive(input logic rx, input logic e, input logic bv, input logic b);
    rx_active = rx;
    eop       = e;
    bit_valid = bv;
    bit_in    = b;
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) drive(1'b1, 1'b0, 1'b1, v[i]);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_packet();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic end_eop();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dec_enable"}, 32'(dec_enable), 32'd0);
    check({tag, "_pid"},        32'(pid),        32'd0);
    check({tag, "_pid_valid"},  32'(pid_valid),  32'd0);
    check({tag, "_byte_out"},   32'(byte_out),   32'd0);
    check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    check({tag, "_pkt_done"},   32'(pkt_done),   32'd0);
    check({tag, "_pkt_error"},  32'(pkt_error),  32'd0);
    check({tag, "_err_code"},   32'(err_code),   32'd0);
    check({tag, "_state"},      32'(state_dbg),  32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mon_en    = 1'b0;
    reset     = 1'b1;
    rx_active = 1'b0;
    eop       = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset  = 1'b0;
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Clean ACK packet, no payload.
    exp_q.push_back(ev(T_PID, 8'h02, 8'd0));
    exp_q.push_back(ev(T_DONE, 8'h00, 8'd0));
    start_packet();
    check("sync_dec_enable", 32'(dec_enable), 32'd1);
    check("sync_state_pid",  32'(state_dbg),  32'd2);
    send_byte(8'hD2, 8);
    end_eop();

    // Data packet with a 15-cycle stall (one short of the timeout).
    exp_q.push_back(ev(T_PID, 8'h03, 8'd0));
    exp_q.push_back(ev(T_BYTE, 8'hA5, 8'd1));
    exp_q.push_back(ev(T_BYTE, 8'h01, 8'd2));
    exp_q.push_back(ev(T_BYTE, 8'hFF, 8'd3));
    exp_q.push_back(ev(T_DONE, 8'h00, 8'd3));
    start_packet();
    send_byte(8'hC3, 8);
    send_byte(8'hA5, 8);
    stall(TIMEOUT - 1);
    send_byte(8'h01, 8);
    send_byte(8'hFF, 8);
    end_eop();
    check("data_byte_count_hold", 32'(byte_count), 32'd3);

    // Bad PID: error 1, decoder disabled while draining.
    exp_q.push_back(ev(T_ERR, 8'h01, 8'd0));
    start_packet();
    send_byte(8'hC4, 8);
    check("badpid_dec_enable", 32'(dec_enable), 32'd0);
    check("badpid_state_drain", 32'(state_dbg), 32'd4);
    send_byte(8'h5A, 3);
    check("badpid_dec_enable_drain", 32'(dec_enable), 32'd0);
    end_eop();
    check("badpid_state_idle", 32'(state_dbg), 32'd0);

    // Misaligned EOP in DATA.
    exp_q.push_back(ev(T_PID, 8'h03, 8'd0));
    exp_q.push_back(ev(T_BYTE, 8'h5A, 8'd1));
    exp_q.push_back(ev(T_ERR, 8'h02, 8'd1));
    start_packet();
    send_byte(8'hC3, 8);
    send_byte(8'h5A, 8);
    send_byte(8'h05, 3);
    end_eop();

    // EOP inside PID.
    exp_q.push_back(ev(T_ERR, 8'h02, 8'd0));
    start_packet();
    send_byte(8'hC3, 4);
    end_eop();

    // Overflow: fifth byte with MAX_BYTES = 4.
    exp_q.push_back(ev(T_PID, 8'h03, 8'd0));
    exp_q.push_back(ev(T_BYTE, 8'h11, 8'd1));
    exp_q.push_back(ev(T_BYTE, 8'h22, 8'd2));
    exp_q.push_back(ev(T_BYTE, 8'h33, 8'd3));
    exp_q.push_back(ev(T_BYTE, 8'h44, 8'd4));
    exp_q.push_back(ev(T_ERR, 8'h03, 8'd4));
    start_packet();
    send_byte(8'hC3, 8);
    send_byte(8'h11, 8);
    send_byte(8'h22, 8);
    send_byte(8'h33, 8);
    send_byte(8'h44, 8);
    send_byte(8'h55, 8);
    check("ovf_state_drain", 32'(state_dbg), 32'd4);
    end_eop();

    // Timeout: 16 cycles without a valid bit in DATA.
    exp_q.push_back(ev(T_PID, 8'h03, 8'd0));
    exp_q.push_back(ev(T_BYTE, 8'h77, 8'd1));
    exp_q.push_back(ev(T_ERR, 8'h03, 8'd1));
    start_packet();
    send_byte(8'hC3, 8);
    send_byte(8'h77, 8);
    stall(TIMEOUT);
    check("tmo_state_drain", 32'(state_dbg), 32'd4);
    end_eop();

    // rx_active drops mid-byte without EOP.
    exp_q.push_back(ev(T_PID, 8'h03, 8'd0));
    exp_q.push_back(ev(T_BYTE, 8'h3C, 8'd1));
    exp_q.push_back(ev(T_ERR, 8'h03, 8'd1));
    start_packet();
    send_byte(8'hC3, 8);
    send_byte(8'h3C, 8);
    send_byte(8'h03, 2);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_state_idle", 32'(state_dbg), 32'd0);

    // Reset mid-DATA, then a clean packet whose EOP coincides with a bit.
    exp_q.push_back(ev(T_PID, 8'h03, 8'd0));
    exp_q.push_back(ev(T_BYTE, 8'h9C, 8'd1));
    start_packet();
    send_byte(8'hC3, 8);
    send_byte(8'h9C, 8);
    send_byte(8'h0F, 4);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_all_zero("midreset");
    reset = 1'b0;
    exp_q.push_back(ev(T_PID, 8'h03, 8'd0));
    exp_q.push_back(ev(T_BYTE, 8'hE1, 8'd1));
    exp_q.push_back(ev(T_DONE, 8'h00, 8'd1));
    start_packet();
    send_byte(8'hC3, 8);
    send_byte(8'hE1, 8);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("eopbit_state_idle", 32'(state_dbg), 32'd0);

    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
